// File: rtl/spi_reg_bridge_if.sv
`default_nettype none
// ============================================================================
// Module   : spi_reg_bridge_if
// Purpose  : Register-file bus between the SPI bridge (master) and the
//            register file (slave). read/write are one-clk strobes.
//            data_read is combinational from addr and is valid in the
//            same clk as read.
// Revision : 1.0 - initial release
// ============================================================================
interface spi_reg_bridge_if;
    logic       read;
    logic       write;
    logic [5:0] addr;
    logic [7:0] data_write;
    logic [7:0] data_read;

    modport master (
        output read,
        output write,
        output addr,
        output data_write,
        input  data_read
    );

    modport slave (
        input  read,
        input  write,
        input  addr,
        input  data_write,
        output data_read
    );
endinterface
`default_nettype wire

// File: rtl/spi_reg_bridge.sv
`default_nettype none
// ============================================================================
// Module   : spi_reg_bridge
// Purpose  : SPI (mode 0) slave to register-file bridge. Byte 0 is the
//            command (bit7 = write, bits5:0 = start address). The following
//            bytes are burst data with an auto-incrementing, wrapping address.
//            All SPI pins are synchronized into clk, which runs >= 8x sclk.
// Revision : 1.0 - initial release
// ============================================================================
module spi_reg_bridge (
    input  logic              clk,
    input  logic              rst,
    input  logic              sclk,
    input  logic              cs_n,
    input  logic              mosi,
    output logic              miso,
    output logic              frame_err,
    spi_reg_bridge_if.master  bus
);

    localparam logic [2:0] c_ST_IDLE     = 3'd0;
    localparam logic [2:0] c_ST_CMD      = 3'd1;
    localparam logic [2:0] c_ST_RD_ISSUE = 3'd2;
    localparam logic [2:0] c_ST_DATA     = 3'd3;
    localparam logic [2:0] c_ST_WR_ISSUE = 3'd4;

    // Synchronizers and edge-detect history.
    logic [1:0] r_sclk_sync;
    logic [1:0] r_cs_sync;
    logic [1:0] r_mosi_sync;
    logic       r_sclk_d;
    logic       r_cs_d;
    // Tracks when the synchronizer pipeline holds real pin samples rather
    // than reset values. A frame can only start after cs_n is genuinely seen
    // high. This prevents a cs_n held low across reset from looking like a
    // fresh falling edge.
    logic [1:0] r_sync_vld;
    logic       r_armed;

    // Frame-decoding state.
    logic [2:0] r_state;
    logic [2:0] r_bit_cnt;
    logic [7:0] r_rx;
    logic [7:0] r_tx;
    logic       r_is_write;
    logic [5:0] r_addr;
    logic [7:0] r_data_write;
    logic       r_read;
    logic       r_write;
    logic       r_miso;
    logic       r_frame_err;

    logic       w_sclk;
    logic       w_cs;
    logic       w_mosi;
    logic       w_sclk_rise;
    logic       w_sclk_fall;
    logic       w_cs_fall;
    logic [7:0] w_rx_next;

    assign w_sclk      = r_sclk_sync[1];
    assign w_cs        = r_cs_sync[1];
    assign w_mosi      = r_mosi_sync[1];
    assign w_sclk_rise = w_sclk & ~r_sclk_d;
    assign w_sclk_fall = ~w_sclk & r_sclk_d;
    assign w_cs_fall   = ~w_cs & r_cs_d & r_armed;
    assign w_rx_next   = {r_rx[6:0], w_mosi};

    // Two-flop synchronizers, edge history and the post-reset arming flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sclk_sync <= 2'b00;
            r_cs_sync   <= 2'b11;
            r_mosi_sync <= 2'b00;
            r_sclk_d    <= 1'b0;
            r_cs_d      <= 1'b1;
            r_sync_vld  <= 2'b00;
            r_armed     <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[0], sclk};
            r_cs_sync   <= {r_cs_sync[0], cs_n};
            r_mosi_sync <= {r_mosi_sync[0], mosi};
            r_sclk_d    <= w_sclk;
            r_cs_d      <= w_cs;
            r_sync_vld  <= {r_sync_vld[0], 1'b1};
            r_armed     <= r_armed | (r_sync_vld[1] & w_cs);
        end
    end

    // Frame FSM. Strobes are registered so read/write are high while the FSM
    // sits in RD_ISSUE/WR_ISSUE. The address increments only after the
    // strobe, so the strobe always sees the address it targets.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= c_ST_IDLE;
            r_bit_cnt    <= 3'd0;
            r_rx         <= 8'h00;
            r_tx         <= 8'h00;
            r_is_write   <= 1'b0;
            r_addr       <= 6'h00;
            r_data_write <= 8'h00;
            r_read       <= 1'b0;
            r_write      <= 1'b0;
            r_miso       <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_read      <= 1'b0;
            r_write     <= 1'b0;
            r_frame_err <= 1'b0;
            if ((r_state != c_ST_IDLE) && w_cs) begin
                // cs_n released: cs_n takes priority over any sclk edge in the
                // same clk. Any partial byte is dropped.
                r_state     <= c_ST_IDLE;
                r_bit_cnt   <= 3'd0;
                r_rx        <= 8'h00;
                r_tx        <= 8'h00;
                r_miso      <= 1'b0;
                r_frame_err <= (r_bit_cnt != 3'd0);
            end else begin
                case (r_state)
                    c_ST_IDLE: begin
                        if (w_cs_fall) begin
                            r_state   <= c_ST_CMD;
                            r_bit_cnt <= 3'd0;
                            r_rx      <= 8'h00;
                        end
                    end
                    c_ST_CMD: begin
                        if (w_sclk_rise) begin
                            r_rx      <= w_rx_next;
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            if (r_bit_cnt == 3'd7) begin
                                r_addr     <= w_rx_next[5:0];
                                r_is_write <= w_rx_next[7];
                                if (w_rx_next[7]) begin
                                    r_state <= c_ST_DATA;
                                end else begin
                                    r_state <= c_ST_RD_ISSUE;
                                    r_read  <= 1'b1;
                                end
                            end
                        end
                    end
                    c_ST_RD_ISSUE: begin
                        r_tx    <= bus.data_read;
                        r_state <= c_ST_DATA;
                    end
                    c_ST_DATA: begin
                        if (w_sclk_fall && !r_is_write) begin
                            r_miso <= r_tx[7];
                            r_tx   <= {r_tx[6:0], 1'b0};
                        end
                        if (w_sclk_rise) begin
                            r_rx      <= w_rx_next;
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            if (r_bit_cnt == 3'd7) begin
                                if (r_is_write) begin
                                    r_data_write <= w_rx_next;
                                    r_write      <= 1'b1;
                                    r_state      <= c_ST_WR_ISSUE;
                                end else begin
                                    r_addr  <= r_addr + 6'd1;
                                    r_read  <= 1'b1;
                                    r_state <= c_ST_RD_ISSUE;
                                end
                            end
                        end
                    end
                    c_ST_WR_ISSUE: begin
                        r_addr  <= r_addr + 6'd1;
                        r_state <= c_ST_DATA;
                    end
                    default: begin
                        r_state <= c_ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign miso           = r_miso;
    assign frame_err      = r_frame_err;
    assign bus.read       = r_read;
    assign bus.write      = r_write;
    assign bus.addr       = r_addr;
    assign bus.data_write = r_data_write;

endmodule
`default_nettype wire

// File: doc/spi_reg_bridge.md
SPI_REG_BRIDGE -- requirements
Module: spi_reg_bridge

Interface
REQ-001 Parameter: none; the block is fixed at 6-bit address and 8-bit data.
REQ-002 clk  input  1  peripheral clock, single clock domain.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 sclk  input  1  SPI serial clock, mode 0, asynchronous to clk.
REQ-005 cs_n  input  1  SPI chip select, active-low, asynchronous to clk.
REQ-006 mosi  input  1  SPI serial data in, MSB first.
REQ-007 miso  output  1  SPI serial data out, MSB first, registered.
REQ-008 read  output  1  register-file read strobe, one clk pulse.
REQ-009 write  output  1  register-file write strobe, one clk pulse.
REQ-010 addr  output  6  register-file address.
REQ-011 data_write  output  8  register-file write data.
REQ-012 data_read  input  8  register-file read data, combinational from addr/read, valid in the same clk as read.
REQ-013 frame_err  output  1  one-clk pulse when a frame aborts mid-byte.

Function
REQ-014 sclk, cs_n and mosi SHALL each pass through a 2-flop synchronizer; sclk rise/fall edges SHALL be detected from the synchronized value; clk SHALL be at least 8x sclk.
REQ-015 Frame: byte 0 = command (bit7 = 1 write / 0 read, bit6 reserved and ignored, bits5:0 start address); bytes 1..N = data.
REQ-016 mosi SHALL be sampled on detected sclk rising edges; miso SHALL change only on detected sclk falling edges or on cs_n deassertion.
REQ-017 FSM states: IDLE, CMD, RD_ISSUE, DATA, WR_ISSUE; a 3-bit bit counter tracks bits within a byte.
REQ-018 IDLE -> CMD on synchronized cs_n falling; bit counter cleared.
REQ-019 CMD: after the 8th rising edge, addr <= cmd[5:0]; go to RD_ISSUE if read, else DATA.
REQ-020 RD_ISSUE: read = 1 for exactly one clk; data_read captured into the tx shift register that clk; then DATA.
REQ-021 DATA (read frame): on each falling edge miso <= tx[7] and tx shifts left; the first falling edge after RD_ISSUE drives bit 7.
REQ-022 DATA (read frame): after the 8th rising edge, addr increments and the FSM returns to RD_ISSUE (read burst).
REQ-023 DATA (write frame): after the 8th rising edge, data_write <= assembled byte, go to WR_ISSUE.
REQ-024 WR_ISSUE: write = 1 for exactly one clk with the current addr; then addr increments and the FSM returns to DATA (write burst).
REQ-025 Address increment SHALL wrap 6'h3F -> 6'h00.
REQ-026 read and write SHALL never be asserted in the same clk.
REQ-027 Synchronized cs_n high in any non-IDLE state SHALL return the FSM to IDLE next clk, drive miso = 0, and discard any partial byte.
REQ-028 frame_err SHALL pulse one clk if cs_n rises with bit counter != 0; a clean byte-aligned end SHALL NOT pulse it.
REQ-029 If cs_n rise and an sclk edge are detected in the same clk, cs_n wins: no strobe is issued.
REQ-030 sclk edges while cs_n is high SHALL be ignored.
REQ-031 A write frame ended after the command byte only SHALL issue no strobe; a read frame SHALL still have issued its single read.

Reset
REQ-032 rst high SHALL immediately force: FSM = IDLE, bit counter = 0, read = 0, write = 0, addr = 6'h00, data_write = 8'h00, miso = 0, frame_err = 0, shift registers = 0, synchronizers = idle (cs_n = 1, sclk = 0).
REQ-033 Reset asserted mid-frame SHALL abort the frame with no strobe and no frame_err; decoding resumes at the next cs_n falling edge after release.

Verification
REQ-034 Write: cs_n low, bytes 0x82, 0x01 -> exactly one write pulse, addr = 0x02, data_write = 0x01, no read.
REQ-035 Read: bytes 0x0A, 0x00 with data_read = 0xA5 at addr 0x0A -> one read pulse at addr 0x0A; miso over byte 1 = 1,0,1,0,0,1,0,1.
REQ-036 Burst wrap: bytes 0xBF, 0x11, 0x22 -> write (0x3F, 0x11) then write (0x00, 0x22).
REQ-037 Abort: bytes 0x85, then 5 data bits, then cs_n high -> no write, one frame_err pulse, FSM in IDLE, miso = 0.
REQ-038 Reset: rst pulsed during the data byte of a write frame -> all outputs 0, no write; the next frame 0x8C, 0x01 -> write (0x0C, 0x01).
